// File: rtl/food_placer_pkg.sv
// Shared definitions for food placement: playfield defaults, coordinate width
// and the placer FSM encoding (also consumed by the game-control FSM).
package food_placer_pkg;

    localparam int COORD_W = 7;
    localparam int GRID_W  = 80;
    localparam int GRID_H  = 60;

    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SAMPLE = 3'd1,
        ST_QUERY  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_SCAN_Q = 3'd4,
        ST_SCAN_W = 3'd5
    } state_e;

endpackage

// File: rtl/food_placer_if.sv
// Signal bundle between the food placer (master) and its environment:
// request/result handshake, LFSR sample inputs and the occupancy lookup.
interface food_placer_if;
    import food_placer_pkg::*;

    logic   PLACE_REQ;
    coord_t RAND_X;
    coord_t RAND_Y;
    logic   RNG_CE;
    logic   QUERY_VALID;
    coord_t QUERY_X;
    coord_t QUERY_Y;
    logic   QUERY_HIT;
    coord_t FOOD_X;
    coord_t FOOD_Y;
    logic   FOOD_VALID;
    logic   PLACE_DONE;
    logic   PLACE_FAIL;
    logic   BUSY;

    modport master (
        input  PLACE_REQ, RAND_X, RAND_Y, QUERY_HIT,
        output RNG_CE, QUERY_VALID, QUERY_X, QUERY_Y,
        output FOOD_X, FOOD_Y, FOOD_VALID, PLACE_DONE, PLACE_FAIL, BUSY
    );

    modport slave (
        output PLACE_REQ, RAND_X, RAND_Y, QUERY_HIT,
        input  RNG_CE, QUERY_VALID, QUERY_X, QUERY_Y,
        input  FOOD_X, FOOD_Y, FOOD_VALID, PLACE_DONE, PLACE_FAIL, BUSY
    );

endinterface

// File: rtl/food_scan_ctr.sv
// Raster X/Y counter for the fallback scan. Exposes its next-state value so the
// caller can register the coordinate it is about to query in the same edge.
module food_scan_ctr
    import food_placer_pkg::*;
#(
    parameter int COLS = 80,
    parameter int ROWS = 60
) (
    input  logic   CLK,
    input  logic   RESET,
    input  logic   clr_i,
    input  logic   adv_i,
    output coord_t nx_o,
    output coord_t ny_o,
    output logic   last_o
);

    localparam coord_t LAST_X = coord_t'(COLS - 1);
    localparam coord_t LAST_Y = coord_t'(ROWS - 1);

    coord_t x_q, y_q;
    coord_t x_d, y_d;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (clr_i) begin
            x_d = '0;
            y_d = '0;
        end else if (adv_i) begin
            if (x_q == LAST_X) begin
                x_d = '0;
                y_d = y_q + coord_t'(1);
            end else begin
                x_d = x_q + coord_t'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign nx_o   = x_d;
    assign ny_o   = y_d;
    assign last_o = (x_q == LAST_X) && (y_q == LAST_Y);

endmodule

// File: rtl/food_placer.sv
// Food placer: draws random in-range cells, checks them against body occupancy,
// and after MAX_TRIES failed samples falls back to a raster scan that always ends.
module food_placer
    import food_placer_pkg::*;
#(
    parameter int GRID_W    = food_placer_pkg::GRID_W,
    parameter int GRID_H    = food_placer_pkg::GRID_H,
    parameter int MAX_TRIES = 16
) (
    input  logic          CLK,
    input  logic          RESET,
    food_placer_if.master bus
);

    localparam int                 TRY_W   = $clog2(MAX_TRIES + 1);
    localparam logic [TRY_W-1:0]   TRY_MAX = TRY_W'(MAX_TRIES);
    localparam logic [COORD_W:0]   LIM_X   = (COORD_W + 1)'(GRID_W);
    localparam logic [COORD_W:0]   LIM_Y   = (COORD_W + 1)'(GRID_H);

    state_e           state_q, state_d;
    logic [TRY_W-1:0] tries_q, tries_d, tries_inc;
    logic             rng_ce_q, rng_ce_d, qv_q, qv_d;
    coord_t           qx_q, qx_d, qy_q, qy_d;
    coord_t           fx_q, fx_d, fy_q, fy_d;
    logic             fv_q, fv_d, done_q, done_d, fail_q, fail_d, busy_q, busy_d;

    logic   sample_ok, hit;
    logic   scan_clr, scan_adv, scan_last;
    coord_t scan_nx, scan_ny;

    assign hit       = bus.QUERY_HIT;
    assign sample_ok = ({1'b0, bus.RAND_X} < LIM_X) && ({1'b0, bus.RAND_Y} < LIM_Y);
    assign tries_inc = (tries_q == TRY_MAX) ? tries_q : tries_q + TRY_W'(1);

    food_scan_ctr #(.COLS(GRID_W), .ROWS(GRID_H)) u_scan (
        .CLK    (CLK),
        .RESET  (RESET),
        .clr_i  (scan_clr),
        .adv_i  (scan_adv),
        .nx_o   (scan_nx),
        .ny_o   (scan_ny),
        .last_o (scan_last)
    );

    // Scan starts from (0,0) whenever it is entered from random sampling.
    assign scan_clr = (state_d == ST_SCAN_Q) && (state_q != ST_SCAN_W);
    assign scan_adv = (state_q == ST_SCAN_W) && hit && !scan_last;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= ST_IDLE;
            tries_q  <= '0;
            rng_ce_q <= 1'b0;
            qv_q     <= 1'b0;
            qx_q     <= '0;
            qy_q     <= '0;
            fx_q     <= '0;
            fy_q     <= '0;
            fv_q     <= 1'b0;
            done_q   <= 1'b0;
            fail_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            tries_q  <= tries_d;
            rng_ce_q <= rng_ce_d;
            qv_q     <= qv_d;
            qx_q     <= qx_d;
            qy_q     <= qy_d;
            fx_q     <= fx_d;
            fy_q     <= fy_d;
            fv_q     <= fv_d;
            done_q   <= done_d;
            fail_q   <= fail_d;
            busy_q   <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (bus.PLACE_REQ) state_d = ST_SAMPLE;
            ST_SAMPLE: begin
                if (sample_ok)                  state_d = ST_QUERY;
                else if (tries_inc == TRY_MAX)  state_d = ST_SCAN_Q;
                else                            state_d = ST_SAMPLE;
            end
            ST_QUERY:  state_d = ST_WAIT;
            ST_WAIT: begin
                if (!hit)                       state_d = ST_IDLE;
                else if (tries_q == TRY_MAX)    state_d = ST_SCAN_Q;
                else                            state_d = ST_SAMPLE;
            end
            ST_SCAN_Q: state_d = ST_SCAN_W;
            ST_SCAN_W: begin
                if (!hit || scan_last)          state_d = ST_IDLE;
                else                            state_d = ST_SCAN_Q;
            end
            default:   state_d = ST_IDLE;
        endcase
    end

    // Output registers are loaded from the state being entered, so each strobe
    // is high exactly while the FSM sits in the corresponding state.
    always_comb begin
        tries_d  = tries_q;
        rng_ce_d = (state_d == ST_SAMPLE);
        qv_d     = (state_d == ST_QUERY) || (state_d == ST_SCAN_Q);
        busy_d   = (state_d != ST_IDLE);
        qx_d     = qx_q;
        qy_d     = qy_q;
        fx_d     = fx_q;
        fy_d     = fy_q;
        fv_d     = fv_q;
        done_d   = 1'b0;
        fail_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.PLACE_REQ) begin
                    fv_d    = 1'b0;
                    tries_d = '0;
                end
            end
            ST_SAMPLE: begin
                tries_d = tries_inc;
                if (sample_ok) begin
                    qx_d = bus.RAND_X;
                    qy_d = bus.RAND_Y;
                end
            end
            ST_WAIT, ST_SCAN_W: begin
                if (!hit) begin
                    fx_d   = qx_q;
                    fy_d   = qy_q;
                    fv_d   = 1'b1;
                    done_d = 1'b1;
                end else if (state_q == ST_SCAN_W && scan_last) begin
                    fail_d = 1'b1;
                end
            end
            default: ;
        endcase
        if (state_d == ST_SCAN_Q) begin
            qx_d = scan_nx;
            qy_d = scan_ny;
        end
    end

    assign bus.RNG_CE      = rng_ce_q;
    assign bus.QUERY_VALID = qv_q;
    assign bus.QUERY_X     = qx_q;
    assign bus.QUERY_Y     = qy_q;
    assign bus.FOOD_X      = fx_q;
    assign bus.FOOD_Y      = fy_q;
    assign bus.FOOD_VALID  = fv_q;
    assign bus.PLACE_DONE  = done_q;
    assign bus.PLACE_FAIL  = fail_q;
    assign bus.BUSY        = busy_q;

endmodule

// File: tb/tb_food_placer.sv
// Directed bench for food_placer: an 80x60 instance with 4 tries and a 4x2
// instance with 2 tries, an occupancy responder and a query/result scoreboard.
module tb_food_placer;
    import food_placer_pkg::*;

    typedef struct packed {
        logic   rng_ce;
        logic   qv;
        coord_t qx;
        coord_t qy;
        coord_t fx;
        coord_t fy;
        logic   fv;
        logic   done;
        logic   fail;
        logic   busy;
    } obs_t;

    logic   CLK = 1'b0;
    logic   RESET;
    logic   req_v [2];
    coord_t rx_v  [2];
    coord_t ry_v  [2];
    logic   hit_v [2];

    int errors = 0;
    int checks = 0;
    int occ_mode;
    logic pend_hit;
    logic [13:0] rand_seq [$];
    logic [13:0] exp_q    [$];
    logic [15:0] exp_res  [$];

    always #5 CLK = ~CLK;

    food_placer_if ifa ();
    food_placer_if ifb ();

    assign ifa.PLACE_REQ = req_v[0];
    assign ifa.RAND_X    = rx_v[0];
    assign ifa.RAND_Y    = ry_v[0];
    assign ifa.QUERY_HIT = hit_v[0];
    assign ifb.PLACE_REQ = req_v[1];
    assign ifb.RAND_X    = rx_v[1];
    assign ifb.RAND_Y    = ry_v[1];
    assign ifb.QUERY_HIT = hit_v[1];

    food_placer #(.GRID_W(80), .GRID_H(60), .MAX_TRIES(4)) dut_a (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (ifa.master)
    );

    food_placer #(.GRID_W(4), .GRID_H(2), .MAX_TRIES(2)) dut_b (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (ifb.master)
    );

    function automatic obs_t get_obs(input int d);
        obs_t o;
        if (d == 0)
            o = '{ifa.RNG_CE, ifa.QUERY_VALID, ifa.QUERY_X, ifa.QUERY_Y, ifa.FOOD_X,
                  ifa.FOOD_Y, ifa.FOOD_VALID, ifa.PLACE_DONE, ifa.PLACE_FAIL, ifa.BUSY};
        else
            o = '{ifb.RNG_CE, ifb.QUERY_VALID, ifb.QUERY_X, ifb.QUERY_Y, ifb.FOOD_X,
                  ifb.FOOD_Y, ifb.FOOD_VALID, ifb.PLACE_DONE, ifb.PLACE_FAIL, ifb.BUSY};
        return o;
    endfunction

    // Body occupancy model: 0 empty, 1 = (5,5) plus (0..2,0), 2 = every cell.
    function automatic logic occupied(input coord_t x, input coord_t y);
        case (occ_mode)
            1:       return ((x == 7'd5) && (y == 7'd5)) || ((y == 7'd0) && (x < 7'd3));
            2:       return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic load_rand(input int d);
        rx_v[d] = rand_seq[0][13:7];
        ry_v[d] = rand_seq[0][6:0];
    endtask

    // One clock: the generator advances on RNG_CE, the occupancy answer
    // appears in the cycle after the lookup strobe.
    task automatic tick(input int d);
        obs_t o;
        logic ce;
        o  = get_obs(d);
        ce = o.rng_ce;
        @(posedge CLK);
        #1;
        if (ce && rand_seq.size() > 1) void'(rand_seq.pop_front());
        load_rand(d);
        hit_v[d] = pend_hit;
        o        = get_obs(d);
        pend_hit = o.qv ? occupied(o.qx, o.qy) : 1'b0;
    endtask

    task automatic place(input int d, input int budget, input int extra_req_at,
                         output int cycles, output int ce_count);
        obs_t        o;
        logic [13:0] eq;
        logic [15:0] er;
        bit          fin;
        cycles   = 0;
        ce_count = 0;
        fin      = 0;
        load_rand(d);
        req_v[d] = 1'b1;
        for (int n = 1; n <= budget && !fin; n++) begin
            tick(d);
            req_v[d] = (n == extra_req_at);
            o        = get_obs(d);
            cycles   = n;
            if (o.rng_ce) ce_count++;
            if (o.qv) begin
                if (exp_q.size() == 0) begin
                    chk("extra_query", 64'({o.qx, o.qy}), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    eq = exp_q.pop_front();
                    chk("query_xy", 64'({o.qx, o.qy}), 64'(eq));
                end
            end
            if (o.done || o.fail) begin
                fin = 1;
                er  = exp_res.pop_front();
                chk("done_fail", 64'({o.fail, o.done}), 64'(er[15:14]));
                chk("food_valid", 64'(o.fv), 64'(er[14]));
                chk("busy_at_end", 64'(o.busy), 64'(0));
                if (er[14]) chk("food_xy", 64'({o.fx, o.fy}), 64'(er[13:0]));
            end
        end
        req_v[d] = 1'b0;
        if (!fin) chk("timeout", 64'(0), 64'(1));
        chk("queries_left", 64'(exp_q.size()), 64'(0));
        $display("place dut=%0d cycles=%0d rng_ce=%0d", d, cycles, ce_count);
    endtask

    initial begin
        int   cyc, ce;
        obs_t o;
        RESET = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req_v[i] = 1'b0;
            hit_v[i] = 1'b0;
            rx_v[i]  = '0;
            ry_v[i]  = '0;
        end
        occ_mode = 0;
        pend_hit = 1'b0;
        rand_seq = '{14'd0};
        repeat (3) @(posedge CLK);
        #1 RESET = 1'b0;
        tick(0);
        o = get_obs(0);
        chk("reset_outputs_a", 64'({30'd0, o}), 64'(0));
        o = get_obs(1);
        chk("reset_outputs_b", 64'({30'd0, o}), 64'(0));

        // Best case: one sample, one query, done four cycles after the request.
        rand_seq = '{{7'd10, 7'd20}};
        exp_q.push_back({7'd10, 7'd20});
        exp_res.push_back({2'b01, 7'd10, 7'd20});
        place(0, 40, 0, cyc, ce);
        chk("best_latency", 64'(cyc), 64'(4));
        chk("best_rng_ce", 64'(ce), 64'(1));

        // Two out-of-range samples cost one cycle each and issue no lookup.
        rand_seq = '{{7'd100, 7'd5}, {7'd3, 7'd70}, {7'd7, 7'd9}};
        exp_q.push_back({7'd7, 7'd9});
        exp_res.push_back({2'b01, 7'd7, 7'd9});
        place(0, 40, 0, cyc, ce);
        chk("reject_latency", 64'(cyc), 64'(6));
        chk("reject_rng_ce", 64'(ce), 64'(3));

        // Four occupied samples then scan; a repeated request mid-run is ignored.
        occ_mode = 1;
        rand_seq = '{{7'd5, 7'd5}};
        for (int i = 0; i < 4; i++) exp_q.push_back({7'd5, 7'd5});
        for (int i = 0; i < 4; i++) exp_q.push_back({7'(i), 7'd0});
        exp_res.push_back({2'b01, 7'd3, 7'd0});
        place(0, 60, 3, cyc, ce);
        chk("scan_latency", 64'(cyc), 64'(21));
        chk("scan_rng_ce", 64'(ce), 64'(4));
        for (int i = 0; i < 3; i++) begin
            tick(0);
            o = get_obs(0);
            chk("single_done", 64'(o.done), 64'(0));
            chk("idle_after", 64'(o.busy), 64'(0));
        end

        // Fully occupied 4x2 field: every cell scanned, then a fail pulse.
        occ_mode = 2;
        rand_seq = '{{7'd1, 7'd1}};
        exp_q.push_back({7'd1, 7'd1});
        exp_q.push_back({7'd1, 7'd1});
        for (int y = 0; y < 2; y++)
            for (int x = 0; x < 4; x++) exp_q.push_back({7'(x), 7'(y)});
        exp_res.push_back({2'b10, 14'd0});
        place(1, 60, 0, cyc, ce);
        chk("fail_latency", 64'(cyc), 64'(23));
        chk("fail_rng_ce", 64'(ce), 64'(2));

        // Reset while waiting on the first scan cell, then a clean placement.
        load_rand(1);
        req_v[1] = 1'b1;
        tick(1);
        req_v[1] = 1'b0;
        repeat (5) tick(1);
        tick(1);
        o = get_obs(1);
        chk("scan_q_valid", 64'(o.qv), 64'(1));
        chk("scan_q_xy", 64'({o.qx, o.qy}), 64'(0));
        chk("scan_q_rng_ce", 64'(o.rng_ce), 64'(0));
        tick(1);
        o = get_obs(1);
        chk("scan_w_valid", 64'(o.qv), 64'(0));
        chk("scan_w_busy", 64'(o.busy), 64'(1));
        RESET = 1'b1;
        tick(1);
        o = get_obs(1);
        chk("midscan_reset_b", 64'({30'd0, o}), 64'(0));
        o = get_obs(0);
        chk("midscan_reset_a", 64'({30'd0, o}), 64'(0));
        $display("reset during scan applied");
        RESET = 1'b0;
        occ_mode = 0;
        rand_seq = '{{7'd2, 7'd1}};
        exp_q.push_back({7'd2, 7'd1});
        exp_res.push_back({2'b01, 7'd2, 7'd1});
        place(1, 40, 0, cyc, ce);
        chk("post_reset_latency", 64'(cyc), 64'(4));
        chk("post_reset_rng_ce", 64'(ce), 64'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
